ps2_key_decoder: RTL
====================

Name: ps2_key_decoder

Overview:
- Receive-side PS/2 keyboard block: deserialises host-bound PS/2 frames and decodes Set-2 make/break codes.
- Produces the game-control strobes and levels consumed by the top-level FSM and sprite logic: enter, bomb, movement, shoot, slow.
- Sits between the board PS/2 pins and the FSM/player logic, opposite in direction to the VGA pixel output path.
- Runs entirely in the 100 MHz system clock domain.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered ps2_clk level changes.
- TIMEOUT_CYCLES, 100000: idle clk cycles allowed between falling edges inside a frame before the frame is aborted (1 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_data  in  1  raw PS/2 data pin, asynchronous
- scan_code  out  8  last correctly received byte
- scan_valid  out  1  one-cycle pulse: scan_code updated
- frame_err  out  1  one-cycle pulse: start, parity or stop error, or timeout
- enter  out  1  one-cycle pulse on Enter make
- bomb  out  1  one-cycle pulse on X make
- shoot  out  1  level, Z held
- slow  out  1  level, left Shift held
- up, down, left, right  out  1 each  levels, arrow keys held

Behaviour:
- Interface (already decided): single clock clk; reset is synchronous and active-high.
- Reset: all outputs 0, scan_code 8'h00, FSM in IDLE, prefix flags cleared, held flags cleared. Reset mid-frame discards the partial frame.
- Input conditioning: ps2_clk and ps2_data each pass through a 2-FF synchroniser.
- Filtered clock: the filtered ps2_clk level (reset value 1) flips only after FILTER_LEN consecutive samples differ from it.
- Sampling: a falling edge is the filtered level going 1->0. ps2_data is sampled in that same cycle.
- Frame FSM, one step per falling edge:
  - IDLE: data=0 -> DATA, bit count 0. data=1 -> frame_err, stay in IDLE.
  - DATA: shift data in LSB-first. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: require stop=1 and odd parity over the 8 data bits plus the parity bit. Pass -> byte accepted. Fail -> frame_err. Either way -> IDLE.
- Timeout: in any state other than IDLE, a counter reloads on each falling edge. Reaching TIMEOUT_CYCLES -> frame_err, return to IDLE.
- Latency:
  - STOP edge in cycle N -> scan_code and scan_valid in cycle N+1.
  - Key outputs change in cycle N+2.
  - frame_err asserts in cycle N+1 of the failing edge or timeout.
- Byte decoder, acting on each scan_valid:
  - E0 sets ext; F0 sets brk. Neither prefix changes the key outputs.
  - Any other byte is looked up as a (code, ext) pair. Make sets the held flag; break (brk=1) clears it. Both prefixes clear after the byte.
  - Unknown codes change nothing except clearing the prefixes.
  - A frame_err also clears both prefixes.
- Key map, Set 2:
  - Enter 5A, Z 1A, X 22, LShift 12, all ext=0.
  - Up E0 75, Down E0 72, Left E0 6B, Right E0 74.
  - A non-extended 75/72/6B/74 is the keypad; ignore it.
- Pulses: enter and bomb pulse for exactly one cycle on the 0->1 transition of their held flag. Typematic repeats while held produce no further pulse.
- Simultaneous keys: up and down may both be held; no arbitration here, that is the consumer's job.
- Width rules: bit count 4 bits; timeout counter sized by $clog2(TIMEOUT_CYCLES+1); filter counter sized by $clog2(FILTER_LEN+1).

Decomposition:
- Shared package ps2_pkg:
  - frame state enum (IDLE, DATA, PARITY, STOP)
  - prefix constants PS2_EXT=8'hE0, PS2_BRK=8'hF0
  - key-code constants KEY_ENTER, KEY_Z, KEY_X, KEY_LSHIFT, KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT
- One sub-module, ps2_rx_frame: synchroniser, filter, frame FSM and timeout; outputs byte, valid and err.
- ps2_key_decoder instantiates ps2_rx_frame and contains the prefix/key-map logic.

Test Plan:
- Frame 5A with parity 1 and stop 1 (PS/2 clock ~12.5 kHz) -> scan_code=5A, scan_valid one pulse, enter one pulse two cycles after the stop edge.
- Bytes E0 75, then 5A x3 (typematic), then F0 5A -> up=1 and stays 1; enter pulses exactly once; no enter pulse on the break.
- Bytes E0 75, then E0 F0 75 -> up rises, then falls to 0; the E0 and F0 bytes alone never change outputs; prefixes clear afterwards.
- Byte 22 with the parity bit flipped -> frame_err one pulse, no scan_valid, bomb stays 0. A following clean 22 -> bomb pulses.
- Start bit plus 3 data bits, then clock stays high for 100000 cycles -> frame_err; the next full frame 1A decodes correctly, shoot=1.
- Reset asserted mid-frame with shoot and left held -> all outputs 0 the next cycle; a new frame 12 after release decodes correctly, slow=1.
- A 3-cycle glitch low on ps2_clk (FILTER_LEN=8) -> no bit sampled, no frame_err.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types, byte constants and helpers for the PS/2 keyboard receive path.
package ps2_pkg;

    // Frame reception state, advanced once per filtered falling edge of ps2_clk.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    // Set-2 prefix bytes.
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Set-2 key codes used by the game (arrows only count with the E0 prefix).
    localparam logic [7:0] KEY_ENTER  = 8'h5A;
    localparam logic [7:0] KEY_Z      = 8'h1A;
    localparam logic [7:0] KEY_X      = 8'h22;
    localparam logic [7:0] KEY_LSHIFT = 8'h12;
    localparam logic [7:0] KEY_UP     = 8'h75;
    localparam logic [7:0] KEY_DOWN   = 8'h72;
    localparam logic [7:0] KEY_LEFT   = 8'h6B;
    localparam logic [7:0] KEY_RIGHT  = 8'h74;

    // One flag per game-relevant key; used both as held state and as lookup mask.
    typedef struct packed {
        logic enter;
        logic bomb;
        logic shoot;
        logic slow;
        logic up;
        logic down;
        logic left;
        logic right;
    } key_flags_t;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ((^{data, par}) == 1'b1);
    endfunction

    // Map a (code, extended) pair onto its key flag; unknown pairs give an empty mask.
    function automatic key_flags_t key_lookup(input logic [7:0] code, input logic ext);
        key_flags_t m;
        m = key_flags_t'(8'h00);
        if (ext) begin
            case (code)
                KEY_UP:    m.up    = 1'b1;
                KEY_DOWN:  m.down  = 1'b1;
                KEY_LEFT:  m.left  = 1'b1;
                KEY_RIGHT: m.right = 1'b1;
                default:   m = key_flags_t'(8'h00);
            endcase
        end else begin
            case (code)
                KEY_ENTER:  m.enter = 1'b1;
                KEY_X:      m.bomb  = 1'b1;
                KEY_Z:      m.shoot = 1'b1;
                KEY_LSHIFT: m.slow  = 1'b1;
                default:    m = key_flags_t'(8'h00);
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronisers, ps2_clk glitch filter, frame FSM and
// inter-edge timeout. Delivers each good byte with a one-cycle valid pulse and
// each bad frame with a one-cycle error pulse.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_meta_r;
    logic          clk_sync_r;
    logic          data_meta_r;
    logic          data_sync_r;

    logic          filt_r;
    logic [FW-1:0] filt_cnt_r;
    logic          filt_nxt_s;
    logic [FW-1:0] filt_cnt_nxt_s;
    logic          fall_s;

    frame_state_t  state_r;
    frame_state_t  state_nxt_s;
    logic [3:0]    bit_cnt_r;
    logic [3:0]    bit_cnt_nxt_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_nxt_s;
    logic          parity_r;
    logic          parity_nxt_s;
    logic [TW-1:0] tmo_cnt_r;
    logic [TW-1:0] tmo_cnt_nxt_s;
    logic [7:0]    byte_nxt_s;
    logic          valid_nxt_s;
    logic          err_nxt_s;

    // Two-stage synchronisers; both lines idle high on the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Filter: flip the clean level only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        filt_nxt_s     = filt_r;
        filt_cnt_nxt_s = FW'(0);
        if (clk_sync_r != filt_r) begin
            if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
                filt_nxt_s     = ~filt_r;
                filt_cnt_nxt_s = FW'(0);
            end else begin
                filt_cnt_nxt_s = filt_cnt_r + FW'(1);
            end
        end else begin
            filt_cnt_nxt_s = FW'(0);
        end
        fall_s = filt_r & ~filt_nxt_s;
    end

    // Filter state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_r     <= 1'b1;
            filt_cnt_r <= FW'(0);
        end else begin
            filt_r     <= filt_nxt_s;
            filt_cnt_r <= filt_cnt_nxt_s;
        end
    end

    // Frame FSM next state: one step per falling edge, timeout while mid-frame.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        parity_nxt_s  = parity_r;
        tmo_cnt_nxt_s = TW'(0);
        byte_nxt_s    = rx_byte;
        valid_nxt_s   = 1'b0;
        err_nxt_s     = 1'b0;
        if (fall_s) begin
            case (state_r)
                IDLE: begin
                    if (!data_sync_r) begin
                        state_nxt_s   = DATA;
                        bit_cnt_nxt_s = 4'd0;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end
                DATA: begin
                    shift_nxt_s   = {data_sync_r, shift_r[7:1]};
                    bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                    if (bit_cnt_r == 4'd7) begin
                        state_nxt_s = PARITY;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end
                PARITY: begin
                    parity_nxt_s = data_sync_r;
                    state_nxt_s  = STOP;
                end
                STOP: begin
                    if (data_sync_r && odd_parity_ok(shift_r, parity_r)) begin
                        byte_nxt_s  = shift_r;
                        valid_nxt_s = 1'b1;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else if (state_r != IDLE) begin
            if (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                err_nxt_s     = 1'b1;
                state_nxt_s   = IDLE;
                tmo_cnt_nxt_s = TW'(0);
            end else begin
                tmo_cnt_nxt_s = tmo_cnt_r + TW'(1);
            end
        end else begin
            tmo_cnt_nxt_s = TW'(0);
        end
    end

    // Frame FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            parity_r  <= 1'b0;
            tmo_cnt_r <= TW'(0);
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            parity_r  <= parity_nxt_s;
            tmo_cnt_r <= tmo_cnt_nxt_s;
            rx_byte   <= byte_nxt_s;
            rx_valid  <= valid_nxt_s;
            rx_err    <= err_nxt_s;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end for the game: receives Set-2 bytes, tracks the E0/F0
// prefixes and turns make/break codes into held levels and press pulses.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err,
    output logic       enter,
    output logic       bomb,
    output logic       shoot,
    output logic       slow,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right
);

    logic [7:0] rx_byte_s;
    logic       rx_valid_s;
    logic       rx_err_s;

    logic       ext_r;
    logic       ext_nxt_s;
    logic       brk_r;
    logic       brk_nxt_s;
    key_flags_t held_r;
    key_flags_t held_nxt_s;
    key_flags_t key_mask_s;
    logic       enter_r;
    logic       enter_nxt_s;
    logic       bomb_r;
    logic       bomb_nxt_s;

    ps2_rx_frame #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte_s),
        .rx_valid (rx_valid_s),
        .rx_err   (rx_err_s)
    );

    // Prefix tracking and held-key update for each received byte or frame error.
    always_comb begin
        ext_nxt_s  = ext_r;
        brk_nxt_s  = brk_r;
        held_nxt_s = held_r;
        key_mask_s = key_lookup(rx_byte_s, ext_r);
        if (rx_valid_s) begin
            if (rx_byte_s == PS2_EXT) begin
                ext_nxt_s = 1'b1;
            end else if (rx_byte_s == PS2_BRK) begin
                brk_nxt_s = 1'b1;
            end else begin
                if (brk_r) begin
                    held_nxt_s = key_flags_t'(held_r & ~key_mask_s);
                end else begin
                    held_nxt_s = key_flags_t'(held_r | key_mask_s);
                end
                ext_nxt_s = 1'b0;
                brk_nxt_s = 1'b0;
            end
        end else if (rx_err_s) begin
            ext_nxt_s = 1'b0;
            brk_nxt_s = 1'b0;
        end else begin
            ext_nxt_s = ext_r;
            brk_nxt_s = brk_r;
        end
        // Press pulses fire only on the released->held transition, so typematic
        // repeats of an already-held key are silent.
        enter_nxt_s = held_nxt_s.enter & ~held_r.enter;
        bomb_nxt_s  = held_nxt_s.bomb & ~held_r.bomb;
    end

    // Decoder state and registered key outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_r   <= 1'b0;
            brk_r   <= 1'b0;
            held_r  <= key_flags_t'(8'h00);
            enter_r <= 1'b0;
            bomb_r  <= 1'b0;
        end else begin
            ext_r   <= ext_nxt_s;
            brk_r   <= brk_nxt_s;
            held_r  <= held_nxt_s;
            enter_r <= enter_nxt_s;
            bomb_r  <= bomb_nxt_s;
        end
    end

    assign scan_code  = rx_byte_s;
    assign scan_valid = rx_valid_s;
    assign frame_err  = rx_err_s;
    assign enter      = enter_r;
    assign bomb       = bomb_r;
    assign shoot      = held_r.shoot;
    assign slow       = held_r.slow;
    assign up         = held_r.up;
    assign down       = held_r.down;
    assign left       = held_r.left;
    assign right      = held_r.right;

endmodule
